// File: rtl/host_cmd_packer_pkg.sv
// host_cmd_packer_pkg: shared FSM encoding, size limits and header field layout
package host_cmd_packer_pkg;
    typedef enum logic [2:0] {IDLE, HDR, CHECK, WAIT_RDY, HDR_WR, DATA, DATA_WR} state_t;
    localparam int MAX_LEN_DEF        = 65;
    localparam int TIMEOUT_CYCLES_DEF = 62500;
    localparam int CMD_LSB  = 0;
    localparam int CMD_MSB  = 7;
    localparam int LEN_LSB  = 8;
    localparam int LEN_MSB  = 15;
    localparam int QUAD_BIT = 16;
    function automatic logic [7:0] hdr_len(input logic [31:0] h);
        return h[LEN_MSB:LEN_LSB];
    endfunction
endpackage

// File: rtl/host_cmd_packer_byte_packer.sv
// byte_packer: assembles 4 bytes little-endian; word/word_valid are valid in the cycle
// the 4th byte is taken, so the consumer never has to stall the byte stream.
module byte_packer (
    input  logic        clk62,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] acc_q, acc_d;
    always_comb begin
        cnt_d = clr ? 2'd0 : in_valid ? cnt_q + 2'd1 : cnt_q;
        acc_d = in_valid ? {in_byte, acc_q[23:8]} : acc_q;
    end
    assign word       = {in_byte, acc_q};
    assign word_valid = in_valid && cnt_q == 2'd3;
    always_ff @(posedge clk62 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/host_cmd_packer.sv
// host_cmd_packer: packs host bytes into header + data dwords for a busy-gated dword port.
// Define PACKER_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle cycles.
module host_cmd_packer
    import host_cmd_packer_pkg::*;
#(
    parameter int MAX_LEN        = MAX_LEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk62,
    input  logic        RESET_N,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        busy,
    output logic        wr,
    output logic [31:0] data_from_PC,
    output logic        frame_done,
    output logic        len_err,
    output logic        timeout
);
    if (MAX_LEN < 0 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("host_cmd_packer: parameter out of range");
    end

    state_t      state_q, state_d;
    logic        rdy_q, rdy_d;
    logic [31:0] hdr_q, hdr_d;
    logic [31:0] dout_q, dout_d;
    logic [7:0]  rem_q, rem_d;
    logic        fd_q, fd_d;
    logic        lerr_q, lerr_d;
    logic        take, pk_valid, tmo_fire;
    logic [31:0] pk_word;

    assign take = rx_valid && rdy_q;

    byte_packer u_pk (
        .clk62      (clk62),
        .rst_n      (RESET_N),
        .clr        (tmo_fire),
        .in_valid   (take),
        .in_byte    (rx_data),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

`ifdef PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d, in_hd;
    assign in_hd     = state_q == HDR || state_q == DATA;
    assign tmo_fire  = in_hd && !take && tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1);
    assign tmo_cnt_d = (take || !in_hd) ? '0 : tmo_cnt_q + TW'(1);
    assign timeout_d = tmo_fire;
    assign timeout   = timeout_q;
    always_ff @(posedge clk62 or negedge RESET_N) begin
        if (!RESET_N) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        fd_d    = 1'b0;
        lerr_d  = 1'b0;
        case (state_q)
            IDLE:     if (take) state_d = HDR;
            HDR: if (pk_valid) begin
                state_d = CHECK;
                hdr_d   = pk_word;
            end
            CHECK: if (int'(hdr_len(hdr_q)) > MAX_LEN) begin
                lerr_d  = 1'b1;
                state_d = IDLE;
            end else begin
                rem_d   = hdr_len(hdr_q);
                state_d = WAIT_RDY;
            end
            WAIT_RDY: if (!busy) begin
                state_d = HDR_WR;
                dout_d  = hdr_q;
            end
            HDR_WR: begin
                fd_d    = rem_q == 8'd0;
                state_d = fd_d ? IDLE : DATA;
            end
            DATA: if (pk_valid) begin
                state_d = DATA_WR;
                dout_d  = pk_word;
            end
            DATA_WR: begin
                rem_d   = rem_q == 8'd0 ? 8'd0 : rem_q - 8'd1;
                fd_d    = rem_q <= 8'd1;
                state_d = fd_d ? IDLE : DATA;
            end
            default:  state_d = IDLE;
        endcase
        // an inter-byte timeout abandons whatever partial frame is in flight
        if (tmo_fire) state_d = IDLE;
        rdy_d = state_d == IDLE || state_d == HDR || state_d == DATA;
    end

    always_ff @(posedge clk62 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            hdr_q   <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            fd_q    <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            hdr_q   <= hdr_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            fd_q    <= fd_d;
            lerr_q  <= lerr_d;
        end
    end

    assign rx_ready     = rdy_q;
    assign wr           = state_q == HDR_WR || state_q == DATA_WR;
    assign data_from_PC = dout_q;
    assign frame_done   = fd_q;
    assign len_err      = lerr_q;
endmodule

// File: tb/tb_host_cmd_packer.sv
// tb_host_cmd_packer: directed and randomized frames against a queue-based frame model.
module tb_host_cmd_packer;
    localparam int MAX_LEN = 65;

    logic        clk62 = 1'b0;
    logic        RESET_N = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, wr, frame_done, len_err, timeout;
    logic [31:0] data_from_PC;
    logic        force_busy = 1'b0, rand_busy_en = 1'b0, rand_bit = 1'b0;
    logic        busy;
    assign busy = force_busy | (rand_busy_en & rand_bit);

    host_cmd_packer dut (
        .clk62        (clk62),
        .RESET_N      (RESET_N),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .busy         (busy),
        .wr           (wr),
        .data_from_PC (data_from_PC),
        .frame_done   (frame_done),
        .len_err      (len_err),
        .timeout      (timeout)
    );

    always #8 clk62 = ~clk62;

    int vectors = 0, miscompares = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {logic [31:0] d; bit hdr; bit last;} wr_t;
    wr_t         exp_q[$];
    wr_t         cur;
    logic [31:0] last_wr = '0;
    bit          fd_pend = 0;
    int          lerr_cnt = 0, exp_lerr = 0, tmo_cnt = 0, wr_cnt = 0;
    logic        busy_s = 1'b0;

    always @(posedge clk62) busy_s <= busy;

    initial forever begin
        @(negedge clk62);
        rand_bit = $urandom_range(0, 3) == 0;
    end

    always @(negedge clk62) begin
        if (!RESET_N) begin
            last_wr = '0;
            fd_pend = 0;
        end else begin
            check("frame_done", frame_done, fd_pend);
            fd_pend = 0;
            if (len_err) lerr_cnt++;
            if (timeout) tmo_cnt++;
`ifndef PACKER_TIMEOUT_EN
            check("timeout_tied", timeout, 0);
`endif
            if (wr) begin
                wr_cnt++;
                if (exp_q.size() == 0) check("unexp_wr", wr, 0);
                else begin
                    cur = exp_q.pop_front();
                    check(cur.hdr ? "hdr_wr" : "data_wr", data_from_PC, cur.d);
                    if (cur.hdr) check("hdr_busy", busy_s, 0);
                    fd_pend = cur.last;
                end
                last_wr = data_from_PC;
            end else check("dout_stable", data_from_PC, last_wr);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk62);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 2000) begin
            @(negedge clk62);
            n++;
        end
        if (n >= 2000) check("rx_ready_wait", rx_ready, 1);
        @(negedge clk62);
        rx_valid = 1'b0;
    endtask

    // Model: header dword from bytes 0..3, len data dwords from the following groups of 4.
    task automatic send_frame(input logic [7:0] fb[$], input int gap_max, input int n_send);
        logic [31:0] h;
        int          len;
        wr_t         e;
        h   = {fb[3], fb[2], fb[1], fb[0]};
        len = int'(h[15:8]);
        if (len > MAX_LEN) exp_lerr++;
        else begin
            e.d = h; e.hdr = 1; e.last = len == 0;
            exp_q.push_back(e);
            for (int k = 0; k < len; k++) begin
                e.d = {fb[4*k+7], fb[4*k+6], fb[4*k+5], fb[4*k+4]};
                e.hdr = 0; e.last = k == len - 1;
                exp_q.push_back(e);
            end
        end
        foreach (fb[i]) if (i < n_send) begin
            send_byte(fb[i]);
            tick($urandom_range(0, gap_max));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || fd_pend) && n < 5000) begin
            tick(1);
            n++;
        end
        check("drain", exp_q.size(), 0);
        tick(3);
        check("len_err_cnt", lerr_cnt, exp_lerr);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fb[$];
        int bad, n, len, w0;
        tick(3);
        check("rst_wr", wr, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_dout", data_from_PC, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_len_err", len_err, 0);
        check("rst_timeout", timeout, 0);
        RESET_N = 1'b1;
        tick(1);
        check("rdy_after_rst", rx_ready, 1);

        fb = '{8'h02, 8'h00, 8'h00, 8'h00};
        send_frame(fb, 0, 99);
        drain();

        fb = '{8'h32, 8'h02, 8'h01, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14,
               8'h15, 8'h16, 8'h17, 8'h18};
        send_frame(fb, 1, 99);
        drain();

        fb = '{8'h5A, 8'd65, 8'h00, 8'h00};
        repeat (260) fb.push_back(8'($urandom));
        send_frame(fb, 0, 9999);
        drain();

        fb = '{8'h07, 8'h42, 8'h00, 8'h00};
        send_frame(fb, 0, 99);
        drain();
        check("rdy_after_len_err", rx_ready, 1);

        fb = '{8'hAA, 8'h01, 8'h01, 8'hFF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(fb, 2, 99);
        drain();

        force_busy = 1'b1;
        fb = '{8'h09, 8'h00, 8'h00, 8'h00};
        send_frame(fb, 0, 99);
        bad = 0;
        repeat (100) begin
            tick(1);
            if (wr || rx_ready) bad++;
        end
        check("busy_hold", bad, 0);
        force_busy = 1'b0;
        n = 0;
        while (!wr && n < 5) begin
            tick(1);
            n++;
        end
        check("busy_release_lat", n >= 1 && n <= 2, 1);
        drain();

        fb = '{8'h05, 8'h02, 8'h00, 8'h00, 8'h21, 8'h22, 8'h23, 8'h24,
               8'h25, 8'h26, 8'h27, 8'h28};
        send_frame(fb, 0, 5);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_wr", wr, 0);
        check("mid_rst_rdy", rx_ready, 0);
        check("mid_rst_dout", data_from_PC, 0);
        exp_q.delete();
        w0 = wr_cnt;
        tick(2);
        RESET_N = 1'b1;
        tick(1);
        check("mid_rst_rdy_rel", rx_ready, 1);
        tick(20);
        check("mid_rst_no_wr", wr_cnt, w0);

`ifdef PACKER_TIMEOUT_EN
        w0 = wr_cnt;
        send_byte(8'h05);
        send_byte(8'h00);
        n = 0;
        while (!timeout && n < 70000) begin
            tick(1);
            n++;
        end
        check("timeout_lat", n, 62500);
        tick(2);
        check("timeout_rdy", rx_ready, 1);
        check("timeout_no_wr", wr_cnt, w0);
        check("timeout_pulses", tmo_cnt, 1);
`else
        fb = '{8'h44, 8'h00, 8'h00, 8'h00};
        send_frame(fb, 0, 2);
        tick(200);
        check("partial_wait_rdy", rx_ready, 1);
        check("partial_no_wr", exp_q.size(), 1);
        send_byte(fb[2]);
        send_byte(fb[3]);
        drain();
`endif
        fb = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34};
        send_frame(fb, 0, 99);
        drain();

        rand_busy_en = 1'b1;
        for (int f = 0; f < 25; f++) begin
            case ($urandom_range(0, 5))
                0:       len = $urandom_range(60, 70);
                1:       len = $urandom_range(66, 255);
                default: len = $urandom_range(0, 6);
            endcase
            fb = '{8'($urandom), 8'(len), 8'($urandom), 8'($urandom)};
            if (len <= MAX_LEN) repeat (4 * len) fb.push_back(8'($urandom));
            send_frame(fb, 2, 9999);
            drain();
        end
        rand_busy_en = 1'b0;
        tick(5);
        check("len_err_total", lerr_cnt, exp_lerr);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
